// File: rtl/mult_adder_collector.sv
`default_nettype none
// ============================================================================
// Module      : mult_adder_collector
// Description : Sink for the multiply-adder tree. Rasters incoming results
//               into a ping-pong frame buffer and presents each completed
//               frame through a ready/release handshake with a registered
//               random-access read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_adder_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int X_SIZE     = 8,
    parameter int Y_SIZE     = 8,
    parameter int X_BITS     = 3,
    parameter int Y_BITS     = 3,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pixel_rdy,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic [X_BITS-1:0]     wr_x,
    output logic [Y_BITS-1:0]     wr_y,
    output logic                  frame_rdy,
    input  logic                  frame_release,
    output logic                  read_bank,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  overflow
);

    localparam int unsigned c_PIXELS = X_SIZE * Y_SIZE;
    localparam int          c_DEPTH  = 2 ** (ADDR_BITS + 1);
    localparam logic [X_BITS-1:0] c_X_LAST = X_BITS'(X_SIZE - 1);
    localparam logic [Y_BITS-1:0] c_Y_LAST = Y_BITS'(Y_SIZE - 1);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [X_BITS-1:0]     r_wr_x;
    logic [Y_BITS-1:0]     r_wr_y;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [1:0]            r_full;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_accept;
    logic                  w_drop;
    logic                  w_x_last;
    logic                  w_frame_done;
    logic                  w_release;
    logic                  w_rd_oob;
    logic [ADDR_BITS-1:0]  w_wr_addr;
    logic [1:0]            w_full_next;

    assign w_accept     = pixel_rdy & ~r_full[r_wr_bank];
    assign w_drop       = pixel_rdy &  r_full[r_wr_bank];
    assign w_x_last     = (r_wr_x == c_X_LAST);
    assign w_frame_done = w_accept & w_x_last & (r_wr_y == c_Y_LAST);
    assign w_release    = frame_release & r_full[r_rd_bank];
    assign w_wr_addr    = ADDR_BITS'(r_wr_y) * ADDR_BITS'(X_SIZE) + ADDR_BITS'(r_wr_x);
    assign w_rd_oob     = (32'(rd_addr) >= c_PIXELS);

    // A completing frame's set is applied after the release's clear so it wins
    // if both ever target the same bank.
    always_comb begin
        w_full_next = r_full;
        if (w_release) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_frame_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                if (w_x_last) begin
                    r_wr_x <= '0;
                    if (r_wr_y == c_Y_LAST) begin
                        r_wr_y    <= '0;
                        r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_wr_y <= r_wr_y + Y_BITS'(1);
                    end
                end else begin
                    r_wr_x <= r_wr_x + X_BITS'(1);
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= pixel_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd_oob) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{r_rd_bank, rd_addr}];
        end
    end

    assign wr_x      = r_wr_x;
    assign wr_y      = r_wr_y;
    assign frame_rdy = r_full[r_rd_bank];
    assign read_bank = r_rd_bank;
    assign rd_data   = r_rd_data;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mult_adder_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_adder_collector
// Description : Directed self-checking bench for mult_adder_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_adder_collector;

    logic        clock = 1'b0;
    logic        reset;

    // 4x4 frame instance
    logic        pixel_rdy;
    logic [15:0] pixel_in;
    logic [1:0]  wr_x;
    logic [1:0]  wr_y;
    logic        frame_rdy;
    logic        frame_release;
    logic        read_bank;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        overflow;

    // 3x2 frame instance with unused address space above the frame
    logic        b_pixel_rdy;
    logic [15:0] b_pixel_in;
    logic [1:0]  b_wr_x;
    logic [0:0]  b_wr_y;
    logic        b_frame_rdy;
    logic        b_frame_release;
    logic        b_read_bank;
    logic [2:0]  b_rd_addr;
    logic [15:0] b_rd_data;
    logic        b_overflow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mult_adder_collector #(
        .DATA_WIDTH(16), .X_SIZE(4), .Y_SIZE(4),
        .X_BITS(2), .Y_BITS(2), .ADDR_BITS(4)
    ) dut (
        .clock(clock), .reset(reset),
        .pixel_rdy(pixel_rdy), .pixel_in(pixel_in),
        .wr_x(wr_x), .wr_y(wr_y),
        .frame_rdy(frame_rdy), .frame_release(frame_release),
        .read_bank(read_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .overflow(overflow)
    );

    mult_adder_collector #(
        .DATA_WIDTH(16), .X_SIZE(3), .Y_SIZE(2),
        .X_BITS(2), .Y_BITS(1), .ADDR_BITS(3)
    ) dut_b (
        .clock(clock), .reset(reset),
        .pixel_rdy(b_pixel_rdy), .pixel_in(b_pixel_in),
        .wr_x(b_wr_x), .wr_y(b_wr_y),
        .frame_rdy(b_frame_rdy), .frame_release(b_frame_release),
        .read_bank(b_read_bank), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .overflow(b_overflow)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [15:0] d);
        pixel_rdy = 1'b1;
        pixel_in  = d;
        tick();
        pixel_rdy = 1'b0;
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e, input string tag);
        rd_addr = a;
        tick();
        check(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic b_send(input logic [15:0] d);
        b_pixel_rdy = 1'b1;
        b_pixel_in  = d;
        tick();
        b_pixel_rdy = 1'b0;
    endtask

    task automatic b_rd(input logic [2:0] a, input logic [15:0] e, input string tag);
        b_rd_addr = a;
        tick();
        check(tag, 32'(b_rd_data), 32'(e));
    endtask

    initial begin
        reset = 1'b1;
        pixel_rdy = 1'b0; pixel_in = '0; frame_release = 1'b0; rd_addr = '0;
        b_pixel_rdy = 1'b0; b_pixel_in = '0; b_frame_release = 1'b0; b_rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1. reset asserted mid-stream
        for (int i = 0; i < 5; i++) send(16'(16'h50 + i));
        check("pre_reset_x", 32'(wr_x), 1);
        check("pre_reset_y", 32'(wr_y), 1);
        pixel_rdy = 1'b1; pixel_in = 16'h77; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0; pixel_rdy = 1'b0;
        check("rst_wr_x", 32'(wr_x), 0);
        check("rst_wr_y", 32'(wr_y), 0);
        check("rst_frame_rdy", 32'(frame_rdy), 0);
        check("rst_read_bank", 32'(read_bank), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_rd_data", 32'(rd_data), 0);

        // 2. back-to-back frame into bank 0
        for (int i = 0; i < 15; i++) send(16'(16'h100 + i));
        check("f0_not_rdy_at_15", 32'(frame_rdy), 0);
        send(16'h10F);
        check("f0_rdy", 32'(frame_rdy), 1);
        check("f0_wr_x", 32'(wr_x), 0);
        check("f0_wr_y", 32'(wr_y), 0);
        check("f0_read_bank", 32'(read_bank), 0);
        for (int i = 0; i < 16; i++) rd(4'(i), 16'(16'h100 + i), "sweep_bank0");

        // 3. frame with idle gaps into bank 1
        for (int i = 0; i < 16; i++) begin
            send(16'(16'h200 + i));
            if (i == 0) begin
                check("gap_p1_x", 32'(wr_x), 1);
                check("gap_p1_y", 32'(wr_y), 0);
            end
            if (i == 3) begin
                check("gap_p4_x", 32'(wr_x), 0);
                check("gap_p4_y", 32'(wr_y), 1);
            end
            repeat ((i % 3) + 1) tick();
            if (i == 0) check("gap_hold_x", 32'(wr_x), 1);
        end
        check("both_full_rdy", 32'(frame_rdy), 1);
        check("both_full_read_bank", 32'(read_bank), 0);

        // 4. both banks full: extra pixel dropped
        send(16'hDEAD);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_wr_x", 32'(wr_x), 0);
        check("ovf_wr_y", 32'(wr_y), 0);
        release_frame();
        check("rel1_read_bank", 32'(read_bank), 1);
        check("rel1_frame_rdy", 32'(frame_rdy), 1);
        for (int i = 0; i < 16; i++) rd(4'(i), 16'(16'h200 + i), "sweep_bank1");
        release_frame();
        check("rel2_frame_rdy", 32'(frame_rdy), 0);
        check("rel2_read_bank", 32'(read_bank), 0);
        rd(4'd0, 16'h100, "drop_not_written");
        check("ovf_sticky", 32'(overflow), 1);

        // 5. release coincident with last pixel of the bank-1 frame
        for (int i = 0; i < 16; i++) send(16'(16'h300 + i));
        check("f2_rdy", 32'(frame_rdy), 1);
        for (int i = 0; i < 15; i++) send(16'(16'h400 + i));
        frame_release = 1'b1;
        send(16'h40F);
        frame_release = 1'b0;
        check("coinc_read_bank", 32'(read_bank), 1);
        check("coinc_frame_rdy", 32'(frame_rdy), 1);
        send(16'h500);
        check("coinc_bank0_free_x", 32'(wr_x), 1);
        rd(4'd15, 16'h40F, "coinc_bank1_last");
        release_frame();
        check("coinc_rel_read_bank", 32'(read_bank), 0);
        check("coinc_rel_frame_rdy", 32'(frame_rdy), 0);
        rd(4'd0, 16'h500, "next_frame_bank0");

        // 6. release ignored while nothing is ready
        release_frame();
        check("idle_rel_read_bank", 32'(read_bank), 0);
        check("idle_rel_frame_rdy", 32'(frame_rdy), 0);
        rd(4'd15, 16'h30F, "rd_addr15");

        // 3x2 instance: non power-of-two wrap and out-of-frame reads
        for (int i = 0; i < 3; i++) b_send(16'(16'h600 + i));
        check("b_row_wrap_x", 32'(b_wr_x), 0);
        check("b_row_wrap_y", 32'(b_wr_y), 1);
        for (int i = 3; i < 6; i++) b_send(16'(16'h600 + i));
        check("b_frame_rdy", 32'(b_frame_rdy), 1);
        check("b_wr_y_wrap", 32'(b_wr_y), 0);
        b_rd(3'd5, 16'h605, "b_rd_last");
        b_rd(3'd6, 16'h0, "b_rd_oob6");
        b_rd(3'd2, 16'h602, "b_rd_mid");
        b_rd(3'd7, 16'h0, "b_rd_oob7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_adder_collector.md
Name: mult_adder_collector

Overview:
- Sink end of the multiply-adder tree output interface.
- Accepts each `pixel_rdy`-qualified result at the end of the pipeline and tracks its own raster x/y write position. Stores each result into a two-bank (ping-pong) output feature-map buffer.
- Presents each completed frame to the next layer through a frame-ready/release handshake and a registered random-access read port.
- Sits between the mult-adder tree/pipeline and the next layer's input stage.

Parameters:
- DATA_WIDTH, 16, width of one result pixel.
- X_SIZE, 8, output pixels per row.
- Y_SIZE, 8, output rows per frame.
- X_BITS, 3, width of x counter; must satisfy 2^X_BITS >= X_SIZE.
- Y_BITS, 3, width of y counter; must satisfy 2^Y_BITS >= Y_SIZE.
- ADDR_BITS, 6, in-bank address width; must satisfy 2^ADDR_BITS >= X_SIZE*Y_SIZE.

Ports:
- clock  input  1  single clock domain; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pixel_rdy  input  1  a valid result is on pixel_in this cycle.
- pixel_in  input  DATA_WIDTH  result pixel from the tree.
- wr_x  output  X_BITS  column the next accepted pixel will be written to.
- wr_y  output  Y_BITS  row the next accepted pixel will be written to.
- frame_rdy  output  1  read bank holds a complete frame.
- frame_release  input  1  consumer has finished with the read bank.
- read_bank  output  1  bank currently presented on the read port.
- rd_addr  input  ADDR_BITS  in-bank read address, equal to y*X_SIZE+x.
- rd_data  output  DATA_WIDTH  registered read data.
- overflow  output  1  sticky: a pixel was dropped because no bank was free.

Behaviour:

Reset:
- wr_x=0, wr_y=0, write bank=0, read_bank=0, both bank-full flags=0, frame_rdy=0, overflow=0, rd_data=0.
- Memory contents are not cleared.
- Reset asserted mid-frame discards the partial frame and any full frames.

Write side:
- When pixel_rdy=1 and the write bank is not full, store pixel_in at {write_bank, wr_y*X_SIZE+wr_x}.
- On an accepted write:
  - If wr_x<X_SIZE-1: wr_x+1.
  - Else: wr_x=0 and wr_y+1.
  - At wr_x=X_SIZE-1 and wr_y=Y_SIZE-1: wr_x=0, wr_y=0, set full[write_bank], toggle write bank, all on the same edge.
- When pixel_rdy=0, counters hold. Gaps between pixels are legal.
- When pixel_rdy=1 and full[write_bank]=1: the pixel is dropped, counters hold, and overflow is set.
  - overflow stays set until reset.

Read side:
- frame_rdy = full[read_bank] (combinational from registers).
- When frame_release=1 and frame_rdy=1: clear full[read_bank] and toggle read_bank on that edge.
- When frame_release=1 and frame_rdy=0: ignored, no state change.
- rd_data <= mem[{read_bank, rd_addr}] every cycle, giving 1-cycle latency. It uses read_bank as registered before the edge.
- If rd_addr >= X_SIZE*Y_SIZE: rd_data <= 0.

Simultaneous events:
- Frame completion and a release in the same cycle both take effect.
  - If they target the same bank, the set from the completing frame wins. This case is not reachable in legal operation, because a bank being written is never full.
- The write to the last pixel of a frame and a release of the other bank in the same cycle are independent.
- A dropped pixel in the same cycle as a release that frees the write bank is still dropped. The release takes effect only on the following edge.

Ordering:
- Frames are presented strictly in completion order.
- At most two complete frames are buffered.

Test Plan:
Run at X_SIZE=4, Y_SIZE=4, ADDR_BITS=4, DATA_WIDTH=16.
1. Assert reset for 2 cycles mid-stream -> wr_x=0, wr_y=0, frame_rdy=0, read_bank=0, overflow=0, rd_data=0 on the cycle after reset.
2. 16 back-to-back pixel_rdy with pixel_in=0x100+i -> frame_rdy rises on the edge after the 16th pixel. wr_x/wr_y then read 0/0. Sweeping rd_addr 0..15 returns 0x100..0x10F, each one cycle after its address.
3. Same 16 pixels with pixel_rdy=0 gaps of 1-3 cycles -> identical stored data; wr_x/wr_y advance only on pixel_rdy cycles (e.g. 1/0 after pixel 1, 0/1 after pixel 4).
4. Fill bank0 and bank1 with no release, then send one more pixel -> overflow=1, wr_x/wr_y stay 0/0. Release once -> read_bank=1 with bank1 data; frame_rdy stays 1. Release again -> frame_rdy=0.
5. Release on the same cycle as the 16th pixel of the bank1 frame (bank0 presented) -> read_bank=1, frame_rdy=1, full[0]=0. The next frame is written to bank0.
6. frame_release pulsed while frame_rdy=0 -> read_bank unchanged. rd_addr=15 returns the stored value; rd_addr beyond X_SIZE*Y_SIZE (exercised at a size where 2^ADDR_BITS > X_SIZE*Y_SIZE) returns 0.
